cp0_vectored: RTL and testbench

CP0_VECTORED -- requirements
Module: cp0_vectored

---
 rtl/cp0_vectored.sv | 189 ++++++++++++++++++
 tb/tb_cp0_vectored.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_vectored.sv
// MIPS-style coprocessor 0: Count/Compare timer, SR/Cause/EPC/PrID and trap sequencing
// with optional vectored interrupt entry points.
module cp0_vectored #(
  parameter int          NUM_HWINT   = 6,
  parameter logic [31:0] TEXT_START  = 32'h0000_3000,
  parameter logic [31:0] KTEXT_BASE  = 32'h0000_4180,
  parameter logic [31:0] VEC_SPACING = 32'h20,
  parameter logic [31:0] PRID        = 32'hbaad_face
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc,
  input  logic                 in_delay_slot,
  input  logic                 is_mfc0,
  input  logic                 is_mtc0,
  input  logic                 is_eret,
  input  logic [4:0]           reg_id,
  input  logic [31:0]          wdata,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 ktrap,
  output logic                 eret_go,
  output logic [31:0]          handler_pc,
  output logic [31:0]          epc,
  output logic [31:0]          rdata
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [31:0]          count_q, count_d;
  logic [31:0]          compare_q, compare_d;
  logic [31:0]          epc_q, epc_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic [NUM_HWINT-1:0] ip_q, ip_d;
  logic                 exl_q, exl_d;
  logic                 ie_q, ie_d;
  logic                 bd_q, bd_d;
  logic                 ti_q, ti_d;
  logic                 iv_q, iv_d;
  logic [4:0]           exc_code_q, exc_code_d;

  logic [NUM_HWINT-1:0] pending;
  logic [NUM_HWINT-1:0] masked;
  logic                 int_req;
  logic                 trap;
  logic                 eret;
  logic                 mtc0_ok;
  logic [2:0]           vec_idx;
  logic [31:0]          trap_pc;
  logic [31:0]          sr_val;
  logic [31:0]          cause_val;

  // Timer interrupt shares the top hardware line.
  always_comb begin
    pending                = hw_int;
    pending[NUM_HWINT-1]   = hw_int[NUM_HWINT-1] | ti_q;
    masked                 = pending & im_q;
    int_req                = (|masked) && ie_q && !exl_q;
    trap                   = !reset && (exc_valid || int_req);
    eret                   = !reset && is_eret && !trap;
    mtc0_ok                = !reset && is_mtc0 && !trap;
    trap_pc                = in_delay_slot ? (pc - 32'd4) : pc;
  end

  always_comb begin
    vec_idx = '0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      if (masked[i]) vec_idx = 3'(i);
    end
    handler_pc = KTEXT_BASE;
    if (!exc_valid && int_req && iv_q)
      handler_pc = KTEXT_BASE + VEC_SPACING * ({29'd0, vec_idx} + 32'd1);
  end

  always_comb begin
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    ip_d       = pending;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    iv_d       = iv_q;
    exc_code_d = exc_code_q;

    if (count_q == compare_q) ti_d = 1'b1;

    // A Compare write clears TI even if the match happens in the same cycle.
    if (mtc0_ok) begin
      case (reg_id)
        REG_COUNT:   count_d = wdata;
        REG_COMPARE: begin
          compare_d = wdata;
          ti_d      = 1'b0;
        end
        REG_SR: begin
          if (!eret) begin
            im_d  = wdata[10 +: NUM_HWINT];
            exl_d = wdata[1];
            ie_d  = wdata[0];
          end
        end
        REG_CAUSE:   iv_d  = wdata[23];
        REG_EPC:     epc_d = {wdata[31:2], 2'b00};
        default:     ;
      endcase
    end

    if (eret) begin
      exl_d      = 1'b0;
      bd_d       = 1'b0;
      exc_code_d = 5'd0;
    end

    if (trap) begin
      exl_d      = 1'b1;
      bd_d       = in_delay_slot;
      epc_d      = {trap_pc[31:2], 2'b00};
      exc_code_d = exc_valid ? exc_code : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= TEXT_START;
      im_q       <= '1;
      ip_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b1;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      iv_q       <= 1'b0;
      exc_code_q <= 5'd0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      iv_q       <= iv_d;
      exc_code_q <= exc_code_d;
    end
  end

  always_comb begin
    sr_val                    = '0;
    sr_val[10 +: NUM_HWINT]   = im_q;
    sr_val[1]                 = exl_q;
    sr_val[0]                 = ie_q;
    cause_val                 = '0;
    cause_val[31]             = bd_q;
    cause_val[30]             = ti_q;
    cause_val[23]             = iv_q;
    cause_val[10 +: NUM_HWINT] = ip_q;
    cause_val[6:2]            = exc_code_q;

    rdata = '0;
    if (is_mfc0 && !reset) begin
      case (reg_id)
        REG_COUNT:   rdata = count_q;
        REG_COMPARE: rdata = compare_q;
        REG_SR:      rdata = sr_val;
        REG_CAUSE:   rdata = cause_val;
        REG_EPC:     rdata = epc_q;
        REG_PRID:    rdata = PRID;
        default:     rdata = '0;
      endcase
    end
  end

  assign ktrap   = trap;
  assign eret_go = eret;
  assign epc     = epc_q;

endmodule

// File: tb/tb_cp0_vectored.sv
// Directed bench for cp0_vectored: reset values, trap entry, vectoring, priority,
// timer and Count wrap, each scenario in its own task.
module tb_cp0_vectored;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic        is_mfc0, is_mtc0, is_eret;
  logic [4:0]  reg_id;
  logic [31:0] wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        ktrap, eret_go;
  logic [31:0] handler_pc, epc, rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cp0_vectored dut (
    .clk(clk), .reset(reset), .pc(pc), .in_delay_slot(in_delay_slot),
    .is_mfc0(is_mfc0), .is_mtc0(is_mtc0), .is_eret(is_eret),
    .reg_id(reg_id), .wdata(wdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .hw_int(hw_int), .ktrap(ktrap), .eret_go(eret_go), .handler_pc(handler_pc),
    .epc(epc), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; values are sampled 1ns later.
  task automatic rd(input logic [4:0] id, output logic [31:0] v);
    @(negedge clk);
    is_mfc0 = 1'b1;
    reg_id  = id;
    #1;
    v = rdata;
    is_mfc0 = 1'b0;
  endtask

  task automatic wr(input logic [4:0] id, input logic [31:0] d);
    @(negedge clk);
    is_mtc0 = 1'b1;
    reg_id  = id;
    wdata   = d;
    @(posedge clk);
    #1;
    is_mtc0 = 1'b0;
  endtask

  task automatic do_eret();
    @(negedge clk);
    is_eret = 1'b1;
    @(posedge clk);
    #1;
    is_eret = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v, v2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hw_int = 6'h3f; exc_valid = 1'b1; is_eret = 1'b1; is_mfc0 = 1'b1; reg_id = 5'd12;
    #1;
    total_cnt++; if (ktrap !== 1'b0) $display("FAIL rst_ktrap: got %b expected 0", ktrap); else pass_cnt++;
    total_cnt++; if (eret_go !== 1'b0) $display("FAIL rst_eret_go: got %b expected 0", eret_go); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", rdata); else pass_cnt++;
    hw_int = 6'h0; exc_valid = 1'b0; is_eret = 1'b0; reset = 1'b0;
    is_mtc0 = 1'b1; reg_id = 5'd11; wdata = 32'h1000_0000;
    #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_compare_pre: got %h expected 0", rdata); else pass_cnt++;
    total_cnt++; if (ktrap !== 1'b0) $display("FAIL rst_ktrap_after: got %b expected 0", ktrap); else pass_cnt++;
    @(posedge clk);
    #1;
    is_mtc0 = 1'b0; is_mfc0 = 1'b0;
    rd(5'd12, v);
    total_cnt++; if (v !== 32'h0000_fc01) $display("FAIL rst_sr: got %h expected 0000fc01", v); else pass_cnt++;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rst_cause: got %h expected 0", v); else pass_cnt++;
    rd(5'd14, v);
    total_cnt++; if (v !== 32'h0000_3000) $display("FAIL rst_epc: got %h expected 00003000", v); else pass_cnt++;
    total_cnt++; if (epc !== 32'h0000_3000) $display("FAIL rst_epc_port: got %h expected 00003000", epc); else pass_cnt++;
    rd(5'd15, v);
    total_cnt++; if (v !== 32'hbaad_face) $display("FAIL prid: got %h expected baadface", v); else pass_cnt++;
    rd(5'd11, v);
    total_cnt++; if (v !== 32'h1000_0000) $display("FAIL compare_wr: got %h expected 10000000", v); else pass_cnt++;
    rd(5'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL unimpl_reg: got %h expected 0", v); else pass_cnt++;
    rd(5'd9, v);
    rd(5'd9, v2);
    total_cnt++; if (v2 !== v + 32'd1) $display("FAIL count_inc: got %h expected %h", v2, v + 32'd1); else pass_cnt++;
  endtask

  task automatic test_int_basic();
    logic [31:0] v;
    @(negedge clk);
    pc = 32'h3010; in_delay_slot = 1'b0; hw_int = 6'b000100;
    #1;
    total_cnt++; if (ktrap !== 1'b1) $display("FAIL int_ktrap: got %b expected 1", ktrap); else pass_cnt++;
    total_cnt++; if (handler_pc !== 32'h4180) $display("FAIL int_handler: got %h expected 00004180", handler_pc); else pass_cnt++;
    @(posedge clk);
    #1;
    hw_int = 6'h0;
    rd(5'd14, v);
    total_cnt++; if (v !== 32'h3010) $display("FAIL int_epc: got %h expected 00003010", v); else pass_cnt++;
    rd(5'd12, v);
    total_cnt++; if (v !== 32'h0000_fc03) $display("FAIL int_sr_exl: got %h expected 0000fc03", v); else pass_cnt++;
    @(negedge clk);
    hw_int = 6'h3f;
    #1;
    total_cnt++; if (ktrap !== 1'b0) $display("FAIL exl_masks: got %b expected 0", ktrap); else pass_cnt++;
    rd(5'd13, v);
    hw_int = 6'h0;
    total_cnt++; if (v !== 32'h0000_fc00) $display("FAIL ip_capture: got %h expected 0000fc00", v); else pass_cnt++;
    @(negedge clk);
    is_eret = 1'b1;
    #1;
    total_cnt++; if (eret_go !== 1'b1) $display("FAIL eret_go: got %b expected 1", eret_go); else pass_cnt++;
    @(posedge clk);
    #1;
    is_eret = 1'b0;
    rd(5'd12, v);
    total_cnt++; if (v !== 32'h0000_fc01) $display("FAIL eret_sr: got %h expected 0000fc01", v); else pass_cnt++;
  endtask

  task automatic test_vectored();
    logic [31:0] v;
    wr(5'd13, 32'hffff_ffff);
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_0000) $display("FAIL iv_write: got %h expected 00800000", v); else pass_cnt++;
    @(negedge clk);
    pc = 32'h3040; hw_int = 6'b001010;
    #1;
    total_cnt++; if (ktrap !== 1'b1) $display("FAIL vec_ktrap: got %b expected 1", ktrap); else pass_cnt++;
    total_cnt++; if (handler_pc !== 32'h4200) $display("FAIL vec_handler3: got %h expected 00004200", handler_pc); else pass_cnt++;
    @(posedge clk);
    #1;
    hw_int = 6'h0;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_2800) $display("FAIL vec_cause: got %h expected 00802800", v); else pass_cnt++;
    @(negedge clk);
    is_eret = 1'b1; is_mtc0 = 1'b1; reg_id = 5'd12; wdata = 32'h0;
    @(posedge clk);
    #1;
    is_eret = 1'b0; is_mtc0 = 1'b0;
    rd(5'd12, v);
    total_cnt++; if (v !== 32'h0000_fc01) $display("FAIL eret_drops_sr_wr: got %h expected 0000fc01", v); else pass_cnt++;
    @(negedge clk);
    pc = 32'h3044; hw_int = 6'b000001;
    #1;
    total_cnt++; if (handler_pc !== 32'h41a0) $display("FAIL vec_handler0: got %h expected 000041a0", handler_pc); else pass_cnt++;
    @(posedge clk);
    #1;
    hw_int = 6'h0;
    do_eret();
  endtask

  task automatic test_exc_priority();
    logic [31:0] v;
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd4; in_delay_slot = 1'b1; pc = 32'h3024; hw_int = 6'b100000;
    is_mtc0 = 1'b1; reg_id = 5'd14; wdata = 32'h1234_5678;
    #1;
    total_cnt++; if (ktrap !== 1'b1) $display("FAIL exc_ktrap: got %b expected 1", ktrap); else pass_cnt++;
    total_cnt++; if (handler_pc !== 32'h4180) $display("FAIL exc_handler: got %h expected 00004180", handler_pc); else pass_cnt++;
    @(posedge clk);
    #1;
    exc_valid = 1'b0; in_delay_slot = 1'b0; hw_int = 6'h0; is_mtc0 = 1'b0;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h8080_8010) $display("FAIL exc_cause: got %h expected 80808010", v); else pass_cnt++;
    rd(5'd14, v);
    total_cnt++; if (v !== 32'h3020) $display("FAIL exc_epc_bd: got %h expected 00003020", v); else pass_cnt++;
    @(negedge clk);
    is_eret = 1'b1; exc_valid = 1'b1; exc_code = 5'd10; pc = 32'h3050;
    #1;
    total_cnt++; if (eret_go !== 1'b0) $display("FAIL eret_vs_exc: got %b expected 0", eret_go); else pass_cnt++;
    total_cnt++; if (ktrap !== 1'b1) $display("FAIL exc_in_exl: got %b expected 1", ktrap); else pass_cnt++;
    @(posedge clk);
    #1;
    is_eret = 1'b0; exc_valid = 1'b0;
    rd(5'd12, v);
    total_cnt++; if (v !== 32'h0000_fc03) $display("FAIL exl_kept: got %h expected 0000fc03", v); else pass_cnt++;
    rd(5'd14, v);
    total_cnt++; if (v !== 32'h3050) $display("FAIL epc_overwrite: got %h expected 00003050", v); else pass_cnt++;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_0028) $display("FAIL exc_cause2: got %h expected 00800028", v); else pass_cnt++;
    do_eret();
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_0000) $display("FAIL eret_cause: got %h expected 00800000", v); else pass_cnt++;
    wr(5'd14, 32'h0000_5557);
    rd(5'd14, v);
    total_cnt++; if (v !== 32'h0000_5554) $display("FAIL epc_wr_align: got %h expected 00005554", v); else pass_cnt++;
  endtask

  task automatic test_timer();
    logic [31:0] v;
    logic [31:0] hp;
    logic        early, seen;
    early = 1'b0; seen = 1'b0; hp = '0;
    pc = 32'h3060;
    wr(5'd11, 32'd20);
    wr(5'd9, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (ktrap) early = 1'b1;
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL timer_early: got %b expected 0", early); else pass_cnt++;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      #1;
      if (ktrap) begin
        seen = 1'b1;
        hp   = handler_pc;
      end
    end
    total_cnt++; if (seen !== 1'b1) $display("FAIL timer_trap_timeout: got %b expected 1", seen); else pass_cnt++;
    total_cnt++; if (hp !== 32'h4240) $display("FAIL timer_handler: got %h expected 00004240", hp); else pass_cnt++;
    @(posedge clk);
    #1;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h4080_8000) $display("FAIL timer_cause: got %h expected 40808000", v); else pass_cnt++;
    wr(5'd11, 32'h1000_0000);
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_8000) $display("FAIL ti_clear: got %h expected 00808000", v); else pass_cnt++;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_0000) $display("FAIL ip_drop: got %h expected 00800000", v); else pass_cnt++;
    do_eret();
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(5'd11, 32'd5);
    wr(5'd9, 32'hffff_ffff);
    rd(5'd9, v);
    total_cnt++; if (v !== 32'hffff_ffff) $display("FAIL count_load: got %h expected ffffffff", v); else pass_cnt++;
    rd(5'd9, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL count_wrap: got %h expected 0", v); else pass_cnt++;
    rd(5'd13, v);
    total_cnt++; if (v !== 32'h0080_0000) $display("FAIL wrap_no_ti: got %h expected 00800000", v); else pass_cnt++;
    total_cnt++; if (ktrap !== 1'b0) $display("FAIL wrap_no_trap: got %b expected 0", ktrap); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; in_delay_slot = 1'b0;
    is_mfc0 = 1'b0; is_mtc0 = 1'b0; is_eret = 1'b0;
    reg_id = 5'd0; wdata = 32'h0; exc_valid = 1'b0; exc_code = 5'd0; hw_int = 6'h0;
    test_reset();
    test_int_basic();
    test_vectored();
    test_exc_priority();
    test_timer();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
